// File: rtl/sync_input_conditioner_pkg.sv
// Shared constants and parameter helpers for the input conditioner.
// Pure compile-time content; no logic.
package sync_input_conditioner_pkg;

    localparam int DEF_THRESH = 4;
    localparam int DEF_CNT_W  = 8;

    // Bits needed to count 0..v-1 (at least 1).
    function automatic int clog2_fn(input int v);
        int n;
        n = 1;
        while ((1 << n) < v) n++;
        return n;
    endfunction

    function automatic bit thresh_ok(input int thresh, input int cnt_w);
        return (thresh >= 1) && (longint'(thresh) <= (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/sync_input_conditioner_debounce_bit.sv
// One bit: consecutive-sample debounce, registered level and edge pulses; q moves THRESH qualified samples after d.
// Optional sticky edge flags under STICKY_EDGE_EN.
module debounce_bit
    import sync_input_conditioner_pkg::*;
#(
    parameter int   THRESH  = DEF_THRESH,
    parameter int   CNT_W   = DEF_CNT_W,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic d,
`ifdef STICKY_EDGE_EN
    input  logic clr,
    output logic rise_seen,
    output logic fall_seen,
`endif
    output logic q,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RST_VAL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample_en) begin
                if (d == q) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    q    <= d;
                    cnt  <= '0;
                    rise <= d;
                    fall <= ~d;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef STICKY_EDGE_EN
    // Set wins over clear so an edge arriving with clr is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_seen <= 1'b0;
            fall_seen <= 1'b0;
        end else begin
            if (rise)     rise_seen <= 1'b1;
            else if (clr) rise_seen <= 1'b0;
            if (fall)     fall_seen <= 1'b1;
            else if (clr) fall_seen <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/sync_input_conditioner.sv
// W-bit debounce/edge-detect stage after the CDC synchronizer; q and pulses appear THRESH qualified samples after d settles.
// Define STICKY_EDGE_EN to add clr/rise_seen/fall_seen sticky edge flags.
module sync_input_conditioner
    import sync_input_conditioner_pkg::*;
#(
    parameter int           W       = 1,
    parameter int           THRESH  = DEF_THRESH,
    parameter int           CNT_W   = DEF_CNT_W,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_en,
    input  logic [W-1:0] d,
`ifdef STICKY_EDGE_EN
    input  logic [W-1:0] clr,
    output logic [W-1:0] rise_seen,
    output logic [W-1:0] fall_seen,
`endif
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    if (!thresh_ok(THRESH, CNT_W)) begin : g_bad_params
        $error("sync_input_conditioner: THRESH must be in 1..2**CNT_W");
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        debounce_bit #(
            .THRESH  (THRESH),
            .CNT_W   (CNT_W),
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .clk       (clk),
            .rst       (rst),
            .sample_en (sample_en),
            .d         (d[i]),
`ifdef STICKY_EDGE_EN
            .clr       (clr[i]),
            .rise_seen (rise_seen[i]),
            .fall_seen (fall_seen[i]),
`endif
            .q         (q[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

endmodule
